// File: rtl/program_loader.sv
// Byte-stream program loader: 4-byte LE word count, N LE instruction words, then PC reset and run.
// Optional checksum byte after the payload when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        ld_en,
  output logic [31:0] Load_data,
  output logic        rst_counter,
  output logic        rd_en,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PRE,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_POST,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  byte_idx;
  logic [23:0] byte_acc;
  logic [15:0] word_num;
  logic [15:0] word_cnt;
  logic        ld_pend;

  logic        byte_xfer;
  logic        load_start;
  logic        hdr_last;
  logic        hdr_bad;
  logic        word_done;
  logic        last_word;
  logic [31:0] asm_word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // Bytes arrive LSB first, so each new byte enters at the top of the accumulator.
  assign asm_word   = {byte_data, byte_acc};
  assign byte_xfer  = byte_valid && byte_ready;
  assign load_start = start && (state == S_IDLE || state == S_RUN || state == S_ERR);
  assign hdr_last   = (state == S_HDR) && byte_xfer && (byte_idx == 2'd3);
  assign hdr_bad    = (asm_word == 32'd0) || (asm_word > MAX_N);
  assign word_done  = (state == S_LOAD) && byte_xfer && (byte_idx == 2'd3);
  assign last_word  = ld_en && ((word_cnt + 16'd1) == word_num);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    byte_ready  = 1'b0;
    ld_en       = 1'b0;
    rst_counter = 1'b0;
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (hdr_last) state_nxt = hdr_bad ? S_ERR : S_PRE;
      end
      S_PRE: begin
        busy        = 1'b1;
        rst_counter = 1'b1;
        state_nxt   = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        ld_en      = ld_pend;
        byte_ready = !ld_pend;
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_POST;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_xfer) state_nxt = (byte_data == csum) ? S_POST : S_ERR;
      end
`endif
      S_POST: begin
        busy        = 1'b1;
        rst_counter = 1'b1;
        state_nxt   = S_RUN;
      end
      S_RUN: begin
        done  = 1'b1;
        rd_en = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ld_pend marks the one cycle after a word completes; it also blocks byte intake that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx  <= '0;
      byte_acc  <= '0;
      word_num  <= '0;
      word_cnt  <= '0;
      ld_pend   <= 1'b0;
      Load_data <= '0;
    end else begin
      if (load_start) begin
        byte_idx <= '0;
        word_cnt <= '0;
        ld_pend  <= 1'b0;
      end
      if (byte_xfer && (state == S_HDR || state == S_LOAD)) begin
        byte_idx <= byte_idx + 2'd1;
        byte_acc <= {byte_data, byte_acc[23:8]};
      end
      if (hdr_last) begin
        word_num <= asm_word[15:0];
      end
      if (word_done) begin
        Load_data <= asm_word;
        ld_pend   <= 1'b1;
      end
      if (ld_en) begin
        ld_pend  <= 1'b0;
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (load_start) begin
      csum <= '0;
    end else if ((state == S_LOAD) && byte_xfer) begin
      csum <= csum + byte_data;
    end
  end
`endif

endmodule
